// File: rtl/alu_op_sequencer.sv
// Multi-cycle valid/ready sequencer in front of the combinational ALU.
// Optional feature: define ALU_SEQ_DIV0_TRAP_EN to reject Div by zero as an error.
module alu_op_sequencer #(
  parameter int LAT_SIMPLE = 1,
  parameter int LAT_MUL    = 4,
  parameter int LAT_DIV    = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_ry,
  input  logic [31:0] req_rb,
  output logic [31:0] alu_ry,
  output logic [31:0] alu_rb,
  output logic [4:0]  alu_opcode,
  input  logic [63:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_zhi,
  output logic [31:0] rsp_zlo,
  output logic        rsp_err,
  output logic        busy
);

  // A latency of zero makes no sense for a captured result, so it is clamped to one.
  localparam int LS   = (LAT_SIMPLE < 1) ? 1 : LAT_SIMPLE;
  localparam int LM   = (LAT_MUL    < 1) ? 1 : LAT_MUL;
  localparam int LD   = (LAT_DIV    < 1) ? 1 : LAT_DIV;
  localparam int LMAX = (LS > LM) ? ((LS > LD) ? LS : LD) : ((LM > LD) ? LM : LD);
  localparam int CW   = $clog2(LMAX) + 1;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   alu_ry_nxt, alu_rb_nxt;
  logic [4:0]    alu_opcode_nxt;
  logic [31:0]   zhi_nxt, zlo_nxt;
  logic          err_nxt;
  logic          reject;

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01100, 5'b01111,
      5'b10000, 5'b10001, 5'b10010: is_legal = 1'b1;
      default:                      is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] start_count(input logic [4:0] op);
    if (op == OP_MUL)      start_count = CW'(LM - 1);
    else if (op == OP_DIV) start_count = CW'(LD - 1);
    else                   start_count = CW'(LS - 1);
  endfunction

  // Requests that never reach the ALU complete on the accept edge with an error.
  always_comb begin
`ifdef ALU_SEQ_DIV0_TRAP_EN
    reject = !is_legal(req_opcode) || ((req_opcode == OP_DIV) && (req_rb == 32'd0));
`else
    reject = !is_legal(req_opcode);
`endif
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    alu_ry_nxt     = alu_ry;
    alu_rb_nxt     = alu_rb;
    alu_opcode_nxt = alu_opcode;
    zhi_nxt        = rsp_zhi;
    zlo_nxt        = rsp_zlo;
    err_nxt        = rsp_err;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (reject) begin
            zhi_nxt   = 32'd0;
            zlo_nxt   = 32'd0;
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            alu_ry_nxt     = req_ry;
            alu_rb_nxt     = req_rb;
            alu_opcode_nxt = req_opcode;
            cnt_nxt        = start_count(req_opcode);
            state_nxt      = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          zhi_nxt   = alu_c[63:32];
          zlo_nxt   = alu_c[31:0];
          err_nxt   = 1'b0;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_ry     <= 32'd0;
      alu_rb     <= 32'd0;
      alu_opcode <= 5'd0;
      rsp_zhi    <= 32'd0;
      rsp_zlo    <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      alu_ry     <= alu_ry_nxt;
      alu_rb     <= alu_rb_nxt;
      alu_opcode <= alu_opcode_nxt;
      rsp_zhi    <= zhi_nxt;
      rsp_zlo    <= zlo_nxt;
      rsp_err    <= err_nxt;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU model on alu_c.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_ry;
  logic [31:0] req_rb;
  logic [31:0] alu_ry;
  logic [31:0] alu_rb;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_c;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_zhi;
  logic [31:0] rsp_zlo;
  logic        rsp_err;
  logic        busy;

  alu_op_sequencer #(.LAT_SIMPLE(1), .LAT_MUL(4), .LAT_DIV(8)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_ry(req_ry), .req_rb(req_rb),
    .alu_ry(alu_ry), .alu_rb(alu_rb), .alu_opcode(alu_opcode), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_zhi(rsp_zhi), .rsp_zlo(rsp_zlo), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; divide by zero returns remainder=dividend, quotient=all ones.
  always_comb begin
    alu_c = 64'd0;
    case (alu_opcode)
      5'b00011: alu_c = {32'd0, alu_ry + alu_rb};
      5'b00100: alu_c = {32'd0, alu_ry - alu_rb};
      5'b01010: alu_c = {32'd0, alu_ry & alu_rb};
      5'b01111: alu_c = {32'd0, alu_ry} * {32'd0, alu_rb};
      5'b10000: alu_c = (alu_rb == 32'd0) ? {alu_ry, 32'hFFFF_FFFF}
                                          : {alu_ry % alu_rb, alu_ry / alu_rb};
      default:  alu_c = 64'd0;
    endcase
  end

  typedef struct {
    string       name;
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  bit   prev_valid = 1'b0;
  int   n_compared = 0;
  int   n_mismatch = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    n_compared++;
    n_mismatch++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: pops on the rising rsp_valid, then checks the response stays put while held.
  always @(negedge clk) begin
    if (clr) begin
      prev_valid = 1'b0;
      have_cur   = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          failNow("unexpected rsp_valid");
          have_cur = 1'b0;
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          checkOutput({cur.name, " zhi"}, 64'(rsp_zhi), 64'(cur.zhi));
          checkOutput({cur.name, " zlo"}, 64'(rsp_zlo), 64'(cur.zlo));
          checkOutput({cur.name, " err"}, 64'(rsp_err), 64'(cur.err));
          checkOutput({cur.name, " latency"}, 64'(cyc - cur.acc), 64'(cur.lat));
        end
      end else if (rsp_valid && have_cur) begin
        checkOutput({cur.name, " held zhi/zlo/err"}, {rsp_zhi, rsp_zlo ^ {31'd0, rsp_err}},
                    {cur.zhi, cur.zlo ^ {31'd0, cur.err}});
        checkOutput({cur.name, " req_ready in DONE"}, 64'(req_ready), 64'd0);
      end
      prev_valid = rsp_valid;
    end
  end

  // Illegal/trapped requests complete on the accept edge itself, so their expected lat is 0.
  task automatic applyStimulus(input string name, input logic [4:0] op, input logic [31:0] ry,
                               input logic [31:0] rb, input logic [31:0] ezhi, input logic [31:0] ezlo,
                               input logic eerr, input int elat, input bit expect_rsp);
    exp_t e;
    bit   ok = 1'b0;
    @(negedge clk);
    req_opcode = op;
    req_ry     = ry;
    req_rb     = rb;
    req_valid  = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      failNow({name, " accept"});
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (expect_rsp) begin
      e.name = name;
      e.zhi  = ezhi;
      e.zlo  = ezlo;
      e.err  = eerr;
      e.lat  = elat;
      e.acc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic waitIdle(input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready && sb.size() == 0) return;
    end
    failNow({name, " return to idle"});
  endtask

  initial begin
    clr        = 1'b1;
    req_valid  = 1'b0;
    req_opcode = 5'd0;
    req_ry     = 32'd0;
    req_rb     = 32'd0;
    rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready/busy/rsp_valid", {req_ready, busy, rsp_valid}, 64'b100);
    checkOutput("reset alu regs", {alu_ry, alu_rb} | 64'(alu_opcode), 64'd0);
    checkOutput("reset rsp regs", {rsp_zhi, rsp_zlo} | 64'(rsp_err), 64'd0);
    clr = 1'b0;

    applyStimulus("add", 5'b00011, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1, 1'b1);
    waitIdle("add");
    applyStimulus("sub", 5'b00100, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, 1'b0, 1, 1'b1);
    waitIdle("sub");
    applyStimulus("and", 5'b01010, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'h0000_F000, 1'b0, 1, 1'b1);
    waitIdle("and");

    applyStimulus("mul", 5'b01111, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("mul alu inputs stable", {alu_ry ^ alu_rb, 27'd0, alu_opcode}, {32'd0, 27'd0, 5'b01111});
      checkOutput("mul alu_ry stable", 64'(alu_ry), 64'h0001_0000);
    end
    waitIdle("mul");

    applyStimulus("div", 5'b10000, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 8, 1'b1);
    waitIdle("div");

    applyStimulus("illegal 11111", 5'b11111, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'd0, 32'd0, 1'b1, 0, 1'b1);
    waitIdle("illegal 11111");
    checkOutput("illegal keeps alu regs", {alu_ry, alu_rb}, {32'd7, 32'd2});
    checkOutput("illegal keeps alu_opcode", 64'(alu_opcode), 64'(5'b10000));
    applyStimulus("illegal 01011", 5'b01011, 32'd1, 32'd1, 32'd0, 32'd0, 1'b1, 0, 1'b1);
    waitIdle("illegal 01011");

`ifdef ALU_SEQ_DIV0_TRAP_EN
    applyStimulus("div by zero", 5'b10000, 32'd9, 32'd0, 32'd0, 32'd0, 1'b1, 0, 1'b1);
    waitIdle("div by zero");
    checkOutput("div by zero alu_rb untouched", 64'(alu_rb), 64'd2);
`else
    applyStimulus("div by zero", 5'b10000, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b0, 8, 1'b1);
    waitIdle("div by zero");
    checkOutput("div by zero alu_rb loaded", 64'(alu_rb), 64'd0);
`endif

    // Response is held while a new request waits; that request must not be taken.
    rsp_ready = 1'b0;
    applyStimulus("held add", 5'b00011, 32'd100, 32'd23, 32'd0, 32'd123, 1'b0, 1, 1'b1);
    req_opcode = 5'b00011;
    req_ry     = 32'd1;
    req_rb     = 32'd1;
    req_valid  = 1'b1;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rsp_valid) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) failNow("held add rsp_valid");
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("hold rsp_valid/req_ready", {rsp_valid, req_ready}, 64'b10);
      checkOutput("hold no new accept", 64'(alu_ry), 64'd100);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    waitIdle("held add");

    // Abort a Div when its counter reads 2 (five edges after accept).
    applyStimulus("aborted div", 5'b10000, 32'd7, 32'd2, 32'd0, 32'd0, 1'b0, 8, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("abort busy before clr", 64'(busy), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    checkOutput("abort state after clr", {req_ready, busy, rsp_valid}, 64'b100);
    checkOutput("abort alu_opcode cleared", 64'(alu_opcode), 64'd0);
    clr = 1'b0;
    begin
      int rises = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (rsp_valid) rises++;
      end
      checkOutput("abort no rsp_valid", 64'(rises), 64'd0);
    end

    applyStimulus("add after abort", 5'b00011, 32'd1, 32'd1, 32'd0, 32'd2, 1'b0, 1, 1'b1);
    waitIdle("add after abort");

    if (sb.size() != 0) failNow("scoreboard not drained");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
